// File: rtl/clk_wiz_0.sv
// clk_wiz_0: behavioural stand-in for the vendor clock wizard.
//
// Derives a glitch-free output clock from the board clock and reports lock
// status once a fixed settle time has elapsed after reset release.
//
// Parameters
//   DIV          output divide ratio (>= 1); w_clk_out = w_clk / DIV
//   LOCK_CYCLES  w_clk rising edges after reset release before w_locked (>= 1)
//
// Ports (positional order is fixed: w_clk_out, w_rst, w_locked, w_clk)
//   w_clk_out  out  generated clock, low while unlocked
//   w_rst      in   synchronous active-high reset (tied low at the top level)
//   w_locked   out  registered lock flag, high once w_clk_out is stable
//   w_clk      in   reference clock
//
// All registers carry power-up values equal to their reset values, so the
// block comes up correctly with w_rst permanently tied low.
module clk_wiz_0 #(
  parameter int DIV         = 1,
  parameter int LOCK_CYCLES = 64
) (
  output logic w_clk_out,
  input  logic w_rst,
  output logic w_locked,
  input  logic w_clk
);

  // ---------------------------------------------------------------------------
  // Lock counter: counts released edges and saturates at LOCK_CYCLES.
  // ---------------------------------------------------------------------------
  localparam int LW = $clog2(LOCK_CYCLES + 1);
  localparam logic [LW-1:0] LOCK_MAX = LW'(LOCK_CYCLES);

  logic [LW-1:0] r_lock_cnt = '0;
  logic          r_locked   = 1'b0;
  logic [LW-1:0] lock_cnt_next;

  always_comb begin
    lock_cnt_next = r_lock_cnt;
    if (r_lock_cnt != LOCK_MAX) begin
      lock_cnt_next = r_lock_cnt + 1'b1;
    end
  end

  // w_locked rises on the edge where the count reaches LOCK_CYCLES and,
  // because the count saturates there, stays high until the next reset.
  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      r_lock_cnt <= '0;
      r_locked   <= 1'b0;
    end else begin
      r_lock_cnt <= lock_cnt_next;
      r_locked   <= (lock_cnt_next == LOCK_MAX);
    end
  end

  assign w_locked = r_locked;

  // ---------------------------------------------------------------------------
  // Output clock generation.
  // ---------------------------------------------------------------------------
  generate
    if (DIV == 1) begin : g_pass
      // The enable is retimed on the falling edge, i.e. while w_clk is low,
      // so the AND gate can only open or close during a low phase: the output
      // never produces a partial high pulse when lock is gained or lost.
      logic r_en = 1'b0;

      always_ff @(negedge w_clk) begin
        r_en <= r_locked;
      end

      assign w_clk_out = w_clk & r_en;
    end else begin : g_div
      localparam int CW   = $clog2(DIV);
      localparam int HIGH = (DIV + 1) / 2;
      localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
      localparam logic [CW-1:0] HIGH_C  = CW'(HIGH);

      logic [CW-1:0] r_cnt = '0;
      logic          r_out = 1'b0;

      // r_cnt is the phase index (0 .. DIV-1) of the input cycle that begins
      // at this edge; the output is high for the first HIGH phases. Holding
      // the counter at 0 while unlocked makes the first edge after lock start
      // a full-length high phase.
      always_ff @(posedge w_clk) begin
        if (w_rst || !r_locked) begin
          r_cnt <= '0;
          r_out <= 1'b0;
        end else begin
          r_cnt <= (r_cnt == CNT_MAX) ? '0 : r_cnt + 1'b1;
          r_out <= (r_cnt < HIGH_C);
        end
      end

      assign w_clk_out = r_out;
    end
  endgenerate

endmodule

// File: tb/tb_clk_wiz_0.sv
// Testbench for clk_wiz_0. Several instances share one reference clock:
//   u_d1  DIV=1, LOCK_CYCLES=4, reset tied low from time 0
//   u_d4  DIV=4, LOCK_CYCLES=2, one-cycle reset at edge 60
//   u_d3  DIV=3, LOCK_CYCLES=2, checked over 10 output periods
//   u_d2  DIV=2, LOCK_CYCLES=4, reset at power-up and for 3 cycles at edge 50
//   u_def default parameters, hooked up like the FPGA top level, driving a
//         small LED counter on the generated clock
// Edge n is the n-th rising edge of w_clk (time 10n-5). Outputs are sampled
// 1 time unit after each rising and each falling edge.
module tb_clk_wiz_0;

  // Clock and resets
  logic w_clk = 1'b0;
  always #5 w_clk = ~w_clk;

  logic rst_d1 = 1'b0;
  logic rst_d4 = 1'b0;
  logic rst_d3 = 1'b0;
  logic rst_d2 = 1'b1;

  logic d1_out, d1_lock;
  logic d4_out, d4_lock;
  logic d3_out, d3_lock;
  logic d2_out, d2_lock;
  logic w_clk2, w_locked;

  clk_wiz_0 #(.DIV(1), .LOCK_CYCLES(4)) u_d1 (
    .w_clk_out(d1_out), .w_rst(rst_d1), .w_locked(d1_lock), .w_clk(w_clk));
  clk_wiz_0 #(.DIV(4), .LOCK_CYCLES(2)) u_d4 (
    .w_clk_out(d4_out), .w_rst(rst_d4), .w_locked(d4_lock), .w_clk(w_clk));
  clk_wiz_0 #(.DIV(3), .LOCK_CYCLES(2)) u_d3 (
    .w_clk_out(d3_out), .w_rst(rst_d3), .w_locked(d3_lock), .w_clk(w_clk));
  clk_wiz_0 #(.DIV(2), .LOCK_CYCLES(4)) u_d2 (
    .w_clk_out(d2_out), .w_rst(rst_d2), .w_locked(d2_lock), .w_clk(w_clk));
  clk_wiz_0 u_def (
    .w_clk_out(w_clk2), .w_rst(1'b0), .w_locked(w_locked), .w_clk(w_clk));

  // LED register clocked by the processor clock, as in the top level
  logic [7:0] led_cnt = 8'd0;
  always @(posedge w_clk2) led_cnt <= led_cnt + 8'd1;

  // Pulse-width monitor on the pass-through output: every high pulse must
  // last a full half period (5 time units).
  int  runt_cnt = 0;
  time t_rise   = 0;
  always @(posedge d1_out) t_rise = $time;
  always @(negedge d1_out) if (($time - t_rise) < 5) runt_cnt++;

  // Hand-computed expectations, index 0 = edge 1
  logic [0:7]  e1_lock = 8'b0001_1111;
  logic [0:7]  e1_out  = 8'b0000_1111;
  logic [0:15] e4_lock = 16'b0111_1111_1111_1111;
  logic [0:15] e4_out  = 16'b0011_0011_0011_0011;
  logic [0:31] e3_out  = 32'b00_110_110_110_110_110_110_110_110_110_110;
  logic [0:11] e2_lock = 12'b0000_0111_1111;
  logic [0:11] e2_out  = 12'b0000_0010_1010;

  // Scoreboard counters
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input int n,
                     input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s at edge %0d: observed %0h expected %0h", tag, n, obs, exp);
    end
  endtask

  initial begin
    for (int n = 1; n <= 70; n++) begin
      @(posedge w_clk);
      #1;
      // DIV=1: lock on edge 4, output follows w_clk from the high phase of edge 5
      if (n <= 8) begin
        chk("d1_lock", n, d1_lock, e1_lock[n-1]);
        chk("d1_out_hi", n, d1_out, e1_out[n-1]);
      end
      // DIV=4: lock on edge 2, 2 high / 2 low starting at edge 3
      if (n <= 16) begin
        chk("d4_lock", n, d4_lock, e4_lock[n-1]);
        chk("d4_out", n, d4_out, e4_out[n-1]);
      end
      // DIV=3: 2 high / 1 low starting at edge 3, ten periods
      if (n <= 32) chk("d3_out", n, d3_out, e3_out[n-1]);
      // DIV=2: reset on edges 1-2, lock on edge 6, high on odd edges from 7
      if (n <= 12) begin
        chk("d2_lock", n, d2_lock, e2_lock[n-1]);
        chk("d2_out", n, d2_out, e2_out[n-1]);
      end
      if (n == 2) rst_d2 = 1'b0;
      // DIV=2 mid-run reset sampled on edges 50, 51, 52
      if (n == 49) begin
        chk("d2_pre_rst_out", n, d2_out, 1'b1);
        rst_d2 = 1'b1;
      end
      if (n == 50) begin
        chk("d2_rst_lock", n, d2_lock, 1'b0);
        chk("d2_rst_out", n, d2_out, 1'b0);
      end
      if (n == 52) begin
        chk("d2_rst_out_hold", n, d2_out, 1'b0);
        rst_d2 = 1'b0;
      end
      if (n == 55) chk("d2_relock_early", n, d2_lock, 1'b0);
      if (n == 56) begin
        chk("d2_relock", n, d2_lock, 1'b1);
        chk("d2_relock_out", n, d2_out, 1'b0);
      end
      if (n == 57) chk("d2_restart_hi", n, d2_out, 1'b1);
      if (n == 58) chk("d2_restart_lo", n, d2_out, 1'b0);
      // DIV=4 one-cycle reset sampled on edge 60
      if (n == 59) begin
        chk("d4_lock_pre", n, d4_lock, 1'b1);
        rst_d4 = 1'b1;
      end
      if (n == 60) begin
        chk("d4_rst_lock", n, d4_lock, 1'b0);
        chk("d4_rst_out", n, d4_out, 1'b0);
        rst_d4 = 1'b0;
      end
      if (n == 61) chk("d4_relock_early", n, d4_lock, 1'b0);
      if (n == 62) begin
        chk("d4_relock", n, d4_lock, 1'b1);
        chk("d4_relock_out", n, d4_out, 1'b0);
      end
      if (n == 63) chk("d4_restart_hi1", n, d4_out, 1'b1);
      if (n == 64) chk("d4_restart_hi2", n, d4_out, 1'b1);
      if (n == 65) chk("d4_restart_lo", n, d4_out, 1'b0);
      // Default instance: lock on edge 64, processor clock from edge 65
      if (n == 63) begin
        chk("def_lock_early", n, w_locked, 1'b0);
        chk("def_out_early", n, w_clk2, 1'b0);
      end
      if (n == 64) begin
        chk("def_lock", n, w_locked, 1'b1);
        chk("def_out_gated", n, w_clk2, 1'b0);
        chk("def_led_idle", n, led_cnt, 8'd0);
      end
      if (n == 65) chk("def_out_run", n, w_clk2, 1'b1);
      if (n == 70) chk("def_led_cnt", n, led_cnt, 8'd6);

      @(negedge w_clk);
      #1;
      if (n <= 8) chk("d1_out_lo", n, d1_out, 1'b0);
      if (n >= 64) chk("def_out_lo", n, w_clk2, 1'b0);
    end
    chk("d1_runt_pulses", 70, runt_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
